// File: rtl/id_emitter_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the identifier-token emitter:
//   - ASCII constants (upper/lower letter bases, digit base, space)
//   - emitter state enumeration
//   - nd_digits(): number of BCD digits needed for an unsigned NUM_W-bit value
// ---------------------------------------------------------------------------
package id_pkg;

  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;
  localparam logic [7:0] ASCII_ZERO    = 8'd48;
  localparam logic [7:0] ASCII_SPACE   = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_LET,
    ST_DIG,
    ST_TERM
  } state_e;

  // 77/256 approximates log10(2) from below; the +1 covers the fractional
  // digit, so the result is exact for every width in the 4..16 range.
  function automatic int nd_digits(input int num_w);
    return (num_w * 77) / 256 + 1;
  endfunction

endpackage

// File: rtl/id_emitter_if.sv
// ---------------------------------------------------------------------------
// id_emitter_if
// Request/character bus between a token requester/consumer (master) and the
// id_emitter (slave).
//   start, base, len, num : token request (master -> slave)
//   char_ready            : consumer accepts char (master -> slave)
//   char, char_valid      : character stream (slave -> master)
//   busy, done            : token status (slave -> master)
// ---------------------------------------------------------------------------
interface id_emitter_if #(
  parameter int NUM_W = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [4:0]       base;
  logic [LEN_W-1:0] len;
  logic [NUM_W-1:0] num;
  logic             char_ready;
  logic [7:0]       char;
  logic             char_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, base, len, num, char_ready,
    input  char, char_valid, busy, done
  );

  modport slave (
    input  start, base, len, num, char_ready,
    output char, char_valid, busy, done
  );
endinterface

// File: rtl/id_emitter_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Multicycle shift-and-add-3 (double dabble) binary to BCD converter.
// One start pulse loads bin_i; NUM_W cycles later done_o rises and bcd_o
// holds ND packed BCD digits (digit 0 = units in bits [3:0]). done_o and
// bcd_o stay valid until the next start pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load and begin conversion
//   bin_i      : binary value, sampled with start_i
//   bcd_o      : ND x 4-bit BCD result
//   done_o     : result valid (level)
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import id_pkg::*;
#(
  parameter int NUM_W = 8,
  localparam int ND   = nd_digits(NUM_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [NUM_W-1:0] bin_i,
  output logic [ND*4-1:0] bcd_o,
  output logic            done_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] shift_q;
  logic [ND*4-1:0]  bcd_q;
  logic [ND*4-1:0]  bcd_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  // Each digit >= 5 is bumped by 3 before the shift so it carries correctly.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 :
                                  bcd_q[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      shift_q <= bin_i;
      bcd_q   <= '0;
      cnt_q   <= CNT_W'(NUM_W);
      run_q   <= 1'b1;
      done_q  <= 1'b0;
    end else if (run_q) begin
      shift_q <= {shift_q[NUM_W-2:0], 1'b0};
      bcd_q   <= {bcd_adj[ND*4-2:0], shift_q[NUM_W-1]};
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/id_emitter.sv
// ---------------------------------------------------------------------------
// id_emitter
// Serialises identifier tokens "<letters><decimal digits><space>", one ASCII
// character per accepted cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_emitter_if.slave
//                start/base/len/num request, char_ready from consumer,
//                char/char_valid stream, busy/done status
// Build option:
//   ID_UPPER_EN : when defined letters are uppercase (65+index), otherwise
//                 lowercase (97+index).
// ---------------------------------------------------------------------------
module id_emitter
  import id_pkg::*;
#(
  parameter int NUM_W = 8,
  parameter int LEN_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  id_emitter_if.slave  bus
);

  localparam int ND   = nd_digits(NUM_W);
  localparam int DI_W = (ND > 1) ? $clog2(ND) : 1;

`ifdef ID_UPPER_EN
  localparam logic [7:0] LETTER_BASE = ASCII_UPPER_A;
`else
  localparam logic [7:0] LETTER_BASE = ASCII_LOWER_A;
`endif

  state_e           state_q, state_d;
  logic [4:0]       letter_q, letter_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [DI_W-1:0]  dig_idx_q, dig_idx_d;
  logic             done_q, done_d;

  logic             conv_start;
  logic             conv_done;
  logic [ND*4-1:0]  bcd;
  logic [DI_W-1:0]  first_sig;
  logic [3:0]       cur_digit;
  logic             out_valid;
  logic [7:0]       out_char;
  logic             accept;

  // The converter samples num on the same edge the FSM leaves IDLE.
  assign conv_start = (state_q == ST_IDLE) && bus.start;

  bin2bcd_seq #(.NUM_W(NUM_W)) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (bus.num),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  // Highest non-zero digit; falls back to the units digit so 0 prints "0".
  always_comb begin
    first_sig = '0;
    for (int i = 0; i < ND; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) first_sig = DI_W'(i);
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < ND; i++) begin
      if (dig_idx_q == DI_W'(i)) cur_digit = bcd[i*4 +: 4];
    end
  end

  // Character output is a pure function of registered state, so it holds
  // by itself while the consumer stalls.
  always_comb begin
    out_valid = 1'b0;
    out_char  = 8'd0;
    case (state_q)
      ST_LET: begin
        out_valid = 1'b1;
        out_char  = LETTER_BASE + {3'b000, letter_q};
      end
      ST_DIG: begin
        out_valid = 1'b1;
        out_char  = ASCII_ZERO + {4'b0000, cur_digit};
      end
      ST_TERM: begin
        out_valid = 1'b1;
        out_char  = ASCII_SPACE;
      end
      default: ;
    endcase
  end

  assign accept = out_valid && bus.char_ready;

  always_comb begin
    state_d   = state_q;
    letter_d  = letter_q;
    left_d    = left_q;
    dig_idx_d = dig_idx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_CONV;
          letter_d = (bus.base > 5'd25) ? 5'd0 : bus.base;
          left_d   = bus.len;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          dig_idx_d = first_sig;
          state_d   = (left_q == '0) ? ST_DIG : ST_LET;
        end
      end
      ST_LET: begin
        if (accept) begin
          letter_d = (letter_q == 5'd25) ? 5'd0 : letter_q + 5'd1;
          left_d   = left_q - 1'b1;
          if (left_q == LEN_W'(1)) state_d = ST_DIG;
        end
      end
      ST_DIG: begin
        if (accept) begin
          if (dig_idx_q == '0) state_d = ST_TERM;
          else                 dig_idx_d = dig_idx_q - 1'b1;
        end
      end
      ST_TERM: begin
        if (accept) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      letter_q  <= '0;
      left_q    <= '0;
      dig_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      letter_q  <= letter_d;
      left_q    <= left_d;
      dig_idx_q <= dig_idx_d;
      done_q    <= done_d;
    end
  end

  assign bus.char       = out_char;
  assign bus.char_valid = out_valid;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_id_emitter.sv
// ---------------------------------------------------------------------------
// tb_id_emitter
// Directed and randomized tokens for id_emitter, checked against a string
// model of the expected token and the documented cycle timing.
// Honors ID_UPPER_EN for the expected letter case.
// ---------------------------------------------------------------------------
module tb_id_emitter;

  localparam int NUM_W = 8;
  localparam int LEN_W = 4;
`ifdef ID_UPPER_EN
  localparam int LB = 65;
`else
  localparam int LB = 97;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  id_emitter_if #(.NUM_W(NUM_W), .LEN_W(LEN_W)) bus ();

  id_emitter #(.NUM_W(NUM_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Token as a plain string: letters from base with a-z wrap, decimal, space.
  function automatic string exp_token(input int b, input int l, input int n);
    string s;
    int    idx;
    s   = "";
    idx = (b > 25) ? 0 : b;
    for (int i = 0; i < l; i++) begin
      s   = {s, $sformatf("%c", LB + idx)};
      idx = (idx + 1) % 26;
    end
    s = {s, $sformatf("%0d ", n)};
    return s;
  endfunction

  // mode 0: ready high; 1: random ready; 2: ready low for 3 cycles on 'y'.
  // poke: pulse start with other operands while the token is in flight.
  task automatic run_token(input int b, input int l, input int n, input int mode, input bit poke);
    string exp_s, got_s;
    int    first_e, done_e, stalls, hold_err, zero_err, busy_err, y_stall;
    logic [7:0] prev_c;
    bit    prev_stall, done_seen, r;
    logic  busy_at_done;

    exp_s = exp_token(b, l, n);
    got_s = "";
    first_e = -1; done_e = -1; stalls = 0; hold_err = 0; zero_err = 0;
    busy_err = 0; y_stall = 0; prev_c = 8'd0; prev_stall = 0; done_seen = 0;
    busy_at_done = 1'bx;

    bus.start      = 1'b1;
    bus.base       = 5'(b);
    bus.len        = LEN_W'(l);
    bus.num        = NUM_W'(n);
    bus.char_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);

    for (int e = 0; e < 600; e++) begin
      @(negedge clk);
      if (prev_stall && (bus.char !== prev_c || bus.char_valid !== 1'b1)) hold_err++;
      if (!bus.char_valid && bus.char !== 8'd0) zero_err++;
      if (bus.done === 1'b1) begin
        done_e       = e;
        done_seen    = 1;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.char_valid && first_e < 0) first_e = e;
      if (poke) begin
        bus.start = (e == NUM_W + 3);
        if (e == NUM_W + 3) begin
          bus.base = 5'd3;
          bus.len  = LEN_W'(1);
          bus.num  = NUM_W'(5);
        end
      end
      case (mode)
        1:       r = ($urandom_range(0, 3) != 0);
        2: begin
          r = !(bus.char_valid && bus.char == 8'(LB + 24) && y_stall < 3);
          if (!r) y_stall++;
        end
        default: r = 1'b1;
      endcase
      bus.char_ready = r;
      if (bus.char_valid && r) got_s = {got_s, $sformatf("%c", bus.char)};
      prev_stall = bus.char_valid && !r;
      prev_c     = bus.char;
      if (prev_stall) stalls++;
    end

    $display("token base=%0d len=%0d num=%0d mode=%0d got=\"%s\" expected=\"%s\" stalls=%0d",
             b, l, n, mode, got_s, exp_s, stalls);
    check("done_seen", 32'(done_seen), 32'd1);
    check("first_char_edge", 32'(first_e), 32'(NUM_W + 1));
    check("done_edge", 32'(done_e), 32'(NUM_W + 1 + exp_s.len() + stalls));
    check("busy_at_done", 32'(busy_at_done), 32'd0);
    check("busy_gaps", 32'(busy_err), 32'd0);
    check("hold_on_stall", 32'(hold_err), 32'd0);
    check("char_zero_when_invalid", 32'(zero_err), 32'd0);
    check("token_length", 32'(got_s.len()), 32'(exp_s.len()));
    for (int i = 0; i < exp_s.len(); i++)
      check($sformatf("char[%0d]", i), 32'(got_s[i]), 32'(exp_s[i]));
    if (mode == 2) check("y_stall_cycles", 32'(y_stall), 32'd3);
  endtask

  initial begin
    bit found;
    int dbg_done;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.num = '0;
    bus.char_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_char", 32'(bus.char), 32'd0);
    check("rst_valid", 32'(bus.char_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_token(23, 3, 42, 0, 0);   // xyz42
    run_token(24, 4, 0, 0, 0);    // yzab0
    run_token(0, 0, 255, 0, 0);   // 255
    run_token(5, 0, 7, 0, 0);     // 7
    run_token(23, 3, 42, 2, 0);   // stall on 'y'
    run_token(30, 5, 99, 0, 1);   // base out of range, start poked mid-token
    run_token(0, 2, 9, 0, 0);     // ab9 / AB9

    // Reset asserted while the second digit is on the bus.
    bus.start = 1'b1; bus.base = 5'd0; bus.len = LEN_W'(1); bus.num = NUM_W'(123);
    bus.char_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    found = 0;
    for (int e = 0; e < 50; e++) begin
      @(negedge clk);
      if (bus.char_valid && bus.char == 8'd50) begin
        found = 1;
        break;
      end
    end
    check("reached_second_digit", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_char", 32'(bus.char), 32'd0);
    check("midrst_valid", 32'(bus.char_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dbg_done = 0;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dbg_done++;
    end
    check("no_done_after_abort", 32'(dbg_done), 32'd0);
    $display("reset abort at second digit of a123, outputs cleared");
    run_token(0, 1, 123, 0, 0);

    for (int k = 0; k < 10; k++)
      run_token(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_emitter.md
# id_emitter

Character-stream generator that produces identifier tokens of the form `<letters><decimal digits><space>`, one 8-bit ASCII character per accepted cycle. It is the source side of the identifier-recognition path: its `char` output drives the identifier-detector FSM directly, or a test harness. It is also used as a stimulus source on the board. A token is described by a base letter, a letter count and a binary number. The block converts the number to decimal internally, then serialises the token.

## Interface
Parameters:
- `NUM_W`, default 8: width of the `num` input. Legal range 4..16.
- `LEN_W`, default 4: width of the `len` input. Maximum letter count is 2^LEN_W−1.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: token request. Sampled only in IDLE.
- `base`, in, 5: index of the first letter, 0..25. Values 26..31 are treated as 0.
- `len`, in, LEN_W: number of letters in the token. 0 is legal.
- `num`, in, NUM_W: unsigned value emitted as decimal.
- `char_ready`, in, 1: consumer accepts `char` this cycle. Tie to 1 for free-running.
- `char`, out, 8: ASCII character. 0 whenever `char_valid` is 0.
- `char_valid`, out, 1: `char` holds a token character.
- `busy`, out, 1: a token is in progress.
- `done`, out, 1: one-cycle pulse after the terminating space has been accepted.

## Operation
- Reset values: `char`=0, `char_valid`=0, `busy`=0, `done`=0. The FSM resets to IDLE.
- States and transitions:
  - IDLE → CONV on `start`=1. `base`, `len` and `num` are latched on that edge.
  - CONV → LET. CONV takes NUM_W cycles of shift-and-add-3 binary-to-BCD conversion. Its output is ND BCD digits, where ND = (NUM_W*77)/256 + 1 (3 for NUM_W=8).
  - LET → DIG once `len` letters have been accepted. If `len`=0, CONV goes straight to DIG.
  - DIG → TERM after the least-significant digit is accepted.
  - TERM → IDLE once the space is accepted. `done`=1 for the cycle after that acceptance.
- Letters:
  - The first letter is `base`; each later letter is the previous one +1.
  - After z the sequence wraps to a (index 25→0).
  - ASCII code is 97+index.
- Digits:
  - Emitted most-significant first, as ASCII 48+d.
  - Leading zeros are suppressed.
  - The units digit is always emitted, so `num`=0 produces "0".
- Terminator: ASCII 32.
- Handshake:
  - A character is consumed when `char_valid`=1 and `char_ready`=1 on the same edge.
  - While `char_ready`=0, `char` and `char_valid` hold unchanged.
- `start` while `busy`=1 is ignored. No queuing.
- Reset asserted mid-token:
  - Immediately forces all outputs to their reset values and the FSM to IDLE.
  - The partial token is abandoned; no `done` pulse.

## Timing
- `start` is sampled at edge 0. `busy`=1 from edge 0 through the edge that returns the FSM to IDLE.
- The first character is valid after edge NUM_W+1 (edge 9 for NUM_W=8).
- With `char_ready`=1 throughout, characters appear back-to-back, one per cycle. There are no gaps between LET, DIG and TERM.
- Token length = `len` + significant digits + 1. With ready held high, total cycles from `start` to `done` = 1 + NUM_W + token length.
- `done` and `busy`=0 occur in the same cycle.
- A new `start` is accepted at the first edge where `busy`=0 is sampled; that is also the `done` cycle.

## Configuration
- `ID_UPPER_EN`:
  - Defined: letters are emitted uppercase, ASCII 65+index.
  - Undefined: letters are lowercase, ASCII 97+index.
- Digits, terminator and timing are identical in both builds.

## Structure
- A shared package `id_pkg` holds:
  - the ASCII constants (letter base upper/lower, digit base 48, space 32);
  - the state enumeration;
  - the ND digit-count function.
- One sub-module, `bin2bcd_seq`, is natural. It is the multicycle shift-and-add-3 converter: start pulse in, ND×4-bit BCD plus a done flag out after NUM_W cycles.
- `id_emitter` keeps the FSM, letter counter, digit index and the leading-zero flag.

## Test plan
- `base`=23 ('x'), `len`=3, `num`=42, ready=1 → "xyz42 " on consecutive cycles, first character at edge 9, `done` one cycle after the space.
- `base`=24, `len`=4, `num`=0 → "yzab0 " (letter wrap, single zero digit).
- `len`=0, `num`=255 → "255 ". `num`=7 → "7 " (leading-zero suppression).
- `char_ready` low for 3 cycles while 'y' is valid → 'y' is held stable for 3 cycles; the output sequence is unchanged otherwise.
- `start` pulsed again mid-token → ignored. Reset asserted at the second digit → all outputs 0 immediately, no `done`, and the next `start` produces a full token.
- With `ID_UPPER_EN` defined, `base`=0, `len`=2, `num`=9 → "AB9 ".
